// File: rtl/filter_seq_ctrl.sv
// Pixel-filter sweep sequencer: issues source reads, writes filtered pixels one cycle later.
// Optional FILTER_SEQ_CYCLES_EN adds a saturating cycle_count output.
module filter_seq_ctrl #(
    parameter int ADDR_BITS = 10,
    parameter int CNT_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_BITS-1:0]  num_pixels,
    input  logic                 pause,
    output logic [ADDR_BITS-1:0] src_addr,
    output logic [ADDR_BITS-1:0] dst_addr,
    output logic                 dst_we,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_BITS-1:0]  pix_done
`ifdef FILTER_SEQ_CYCLES_EN
    ,
    output logic [15:0]          cycle_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_BITS-1:0] MAX_PIX = CNT_BITS'(1) << ADDR_BITS;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  src_addr_q, src_addr_d;
    logic [ADDR_BITS-1:0]  dst_addr_q, dst_addr_d;
    logic                  dst_we_q, dst_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_BITS-1:0]   pix_done_q, pix_done_d;
    logic [CNT_BITS-1:0]   n_q, n_d;
    logic [CNT_BITS-1:0]   issued_q, issued_d;
    logic                  issue;
    logic                  start_acc;

    assign issue     = (state_q == RUN) && !pause;
    assign start_acc = (state_q == IDLE) && start;

    always_comb begin
        state_d    = state_q;
        src_addr_d = src_addr_q;
        dst_addr_d = issue ? src_addr_q : dst_addr_q;
        dst_we_d   = issue;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pix_done_d = dst_we_q ? pix_done_q + CNT_BITS'(1) : pix_done_q;
        n_d        = n_q;
        issued_d   = issued_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pix_done_d = '0;
                    if (num_pixels == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        n_d        = (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;
                        src_addr_d = '0;
                        issued_d   = '0;
                        busy_d     = 1'b1;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                // src_addr stops on the last issued address so a full sweep never wraps
                if (issue) begin
                    issued_d = issued_q + CNT_BITS'(1);
                    if (issued_q + CNT_BITS'(1) == n_q) begin
                        state_d = DRAIN;
                    end else begin
                        src_addr_d = src_addr_q + ADDR_BITS'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            dst_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pix_done_q <= '0;
            n_q        <= '0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            dst_we_q   <= dst_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pix_done_q <= pix_done_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
        end
    end

    assign src_addr = src_addr_q;
    assign dst_addr = dst_addr_q;
    assign dst_we   = dst_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pix_done = pix_done_q;

`ifdef FILTER_SEQ_CYCLES_EN
    logic [15:0] cycle_count_q, cycle_count_d;

    // Counting through the done cycle makes the final value equal the start-to-done latency
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_acc) begin
            cycle_count_d = '0;
        end else if ((busy_q || done_q) && cycle_count_q != 16'hFFFF) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl: cycle table plus hand-written sweep sequences.
module tb_filter_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] num_pixels;
    logic        pause;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic        dst_we;
    logic        busy;
    logic        done;
    logic [10:0] pix_done;
`ifdef FILTER_SEQ_CYCLES_EN
    logic [15:0] cycle_count;
`endif

    int passCount = 0;
    int totalCount = 0;

    typedef struct {
        logic        start;
        logic [10:0] num;
        logic        pause;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic        we;
        logic        busy;
        logic        done;
        logic [10:0] pix;
    } vec_t;

    vec_t vecs[13];

    filter_seq_ctrl #(.ADDR_BITS(10), .CNT_BITS(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_pixels (num_pixels),
        .pause      (pause),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .dst_we     (dst_we),
        .busy       (busy),
        .done       (done),
        .pix_done   (pix_done)
`ifdef FILTER_SEQ_CYCLES_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [10:0] np, input logic p);
        start      = s;
        num_pixels = np;
        pause      = p;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic runSweep(input string tag, input int n, input int pause_at, input int pause_len, input int exp_n);
        int wr_cnt = 0;
        int order_err = 0;
        int wrap_err = 0;
        int prev_src = 0;
        int done_at = 0;
        int bound;
        logic [10:0] np;
        bound = exp_n + pause_len + 10;
        np = n[10:0];
        applyStimulus(1'b1, np, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= bound && done_at == 0; k++) begin
            @(negedge clk);
            if (dst_we) begin
                if (int'(dst_addr) != wr_cnt) order_err++;
                wr_cnt++;
            end
            if (busy) begin
                if (int'(src_addr) < prev_src) wrap_err++;
                prev_src = int'(src_addr);
            end
            if (done) begin
                done_at = k;
                checkOutput({tag, " pix_done"}, 32'(pix_done), 32'(exp_n));
            end
            applyStimulus(1'b0, np, (k >= pause_at) && (k < pause_at + pause_len));
        end
        checkOutput({tag, " done_cycle"}, 32'(done_at), 32'(exp_n + 2 + pause_len));
        checkOutput({tag, " writes"}, 32'(wr_cnt), 32'(exp_n));
        checkOutput({tag, " order_errors"}, 32'(order_err), 32'd0);
        checkOutput({tag, " wrap_errors"}, 32'(wrap_err), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
`ifdef FILTER_SEQ_CYCLES_EN
        checkOutput({tag, " cycle_count"}, 32'(cycle_count), 32'(exp_n + 2 + pause_len));
`endif
    endtask

    initial begin
        // start, num, pause | src, dst, we, busy, done, pix
        vecs[0]  = '{1'b1, 11'd3, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 11'd0};
        vecs[1]  = '{1'b0, 11'd3, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 11'd0};
        vecs[2]  = '{1'b0, 11'd3, 1'b0, 10'd2, 10'd1, 1'b1, 1'b1, 1'b0, 11'd1};
        vecs[3]  = '{1'b0, 11'd3, 1'b0, 10'd2, 10'd2, 1'b1, 1'b1, 1'b0, 11'd2};
        vecs[4]  = '{1'b0, 11'd3, 1'b0, 10'd2, 10'd2, 1'b0, 1'b0, 1'b1, 11'd3};
        vecs[5]  = '{1'b0, 11'd3, 1'b0, 10'd2, 10'd2, 1'b0, 1'b0, 1'b0, 11'd3};
        vecs[6]  = '{1'b1, 11'd0, 1'b0, 10'd2, 10'd2, 1'b0, 1'b0, 1'b1, 11'd0};
        vecs[7]  = '{1'b0, 11'd0, 1'b0, 10'd2, 10'd2, 1'b0, 1'b0, 1'b0, 11'd0};
        vecs[8]  = '{1'b1, 11'd2, 1'b0, 10'd0, 10'd2, 1'b0, 1'b1, 1'b0, 11'd0};
        vecs[9]  = '{1'b1, 11'd5, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 11'd0};
        vecs[10] = '{1'b1, 11'd7, 1'b0, 10'd1, 10'd1, 1'b1, 1'b1, 1'b0, 11'd1};
        vecs[11] = '{1'b1, 11'd7, 1'b0, 10'd1, 10'd1, 1'b0, 1'b0, 1'b1, 11'd2};
        vecs[12] = '{1'b0, 11'd7, 1'b0, 10'd1, 10'd1, 1'b0, 1'b0, 1'b0, 11'd2};

        reset = 1'b1;
        applyStimulus(1'b0, 11'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset src_addr", 32'(src_addr), 32'd0);
        checkOutput("reset dst_addr", 32'(dst_addr), 32'd0);
        checkOutput("reset dst_we", 32'(dst_we), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset pix_done", 32'(pix_done), 32'd0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].start, vecs[i].num, vecs[i].pause);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d src_addr", i), 32'(src_addr), 32'(vecs[i].src));
            checkOutput($sformatf("vec%0d dst_addr", i), 32'(dst_addr), 32'(vecs[i].dst));
            checkOutput($sformatf("vec%0d dst_we", i), 32'(dst_we), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            checkOutput($sformatf("vec%0d pix_done", i), 32'(pix_done), 32'(vecs[i].pix));
        end

        // Reset mid-sweep while src_addr is 5 and a write is in flight
        applyStimulus(1'b1, 11'd10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 11'd10, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("pre-reset src_addr", 32'(src_addr), 32'd5);
        checkOutput("pre-reset dst_we", 32'(dst_we), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset src_addr", 32'(src_addr), 32'd0);
        checkOutput("midreset dst_addr", 32'(dst_addr), 32'd0);
        checkOutput("midreset dst_we", 32'(dst_we), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset pix_done", 32'(pix_done), 32'd0);

        runSweep("after_reset n3", 3, 0, 0, 3);
        runSweep("paused n8", 8, 4, 4, 8);
        runSweep("full n1024", 1024, 0, 0, 1024);
        runSweep("clamped n2000", 2000, 0, 0, 1024);

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/filter_seq_ctrl.md
Name: filter_seq_ctrl

Overview:
Sequencer for the pixel-filter datapath: source RAM (synchronous read, 1-cycle latency) -> combinational B/W filter -> destination RAM.
- On a start command, sweeps a programmable number of pixels from address 0.
- Drives source read addresses and destination write address/enable with the read latency compensated.
- Supports a pause input and reports busy/done/progress to the top level.
- Replaces the free-running address/state counter in the processing top.

Parameters:
ADDR_BITS, 10, width of source/destination RAM address.
CNT_BITS, ADDR_BITS+1, width of pixel-count input (allows full 2^ADDR_BITS sweep).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
start  input  1  level sampled; begins a sweep when in IDLE
num_pixels  input  CNT_BITS  pixels to process; latched when start is accepted
pause  input  1  suspends issue of new reads while high
src_addr  output  ADDR_BITS  source RAM read address
dst_addr  output  ADDR_BITS  destination RAM write address
dst_we  output  1  destination RAM write enable
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at sweep completion
pix_done  output  CNT_BITS  pixels written so far in current/last sweep

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - src_addr, dst_addr, dst_we, busy, done, pix_done all 0.
  - Latched count cleared.
  - Reset overrides any in-flight write: dst_we is 0 in the cycle after the reset edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and num_pixels!=0: latch N=num_pixels, src_addr=0, issue=1, pix_done=0, busy=1; -> RUN.
  - start=1 and num_pixels==0: -> DONE with no writes.
  - Otherwise hold.
- Issue/write pipeline:
  - An issue at cycle t means src_addr is valid at t. The RAM returns data at t+1.
  - At t+1: dst_addr = address issued at t, dst_we=1 (registered rd_valid).
  - The filter is combinational, so write data is valid in the same cycle as dst_we.
  - Each write increments pix_done by 1.
- RUN:
  - pause=0: issue the current src_addr, then increment src_addr.
  - Issue count reaches N: -> DRAIN. src_addr holds its last issued value (N-1). No wrap.
  - pause=1: no new issue; src_addr holds. An already-issued read still completes its write the next cycle (writes are never gated by pause).
  - Resume on pause=0 continues from the held address. No pixel is skipped or duplicated.
- DRAIN:
  - Final write occurs (dst_we=1, dst_addr=N-1).
  - -> DONE on the next edge.
  - pause is ignored in DRAIN.
- DONE:
  - done=1 and busy=0 for exactly one cycle; -> IDLE.
  - pix_done holds N until the next accepted start.
- Latency: start edge E0 -> first write in the cycle after E1 -> done in the cycle after edge E(N+1), given no pause. Total N+2 cycles start-to-done.
- start while busy (RUN/DRAIN/DONE) is ignored. num_pixels changes during a sweep have no effect.
- num_pixels > 2^ADDR_BITS is clamped to 2^ADDR_BITS.
- Address arithmetic is unsigned ADDR_BITS wide. A full sweep ends at 2^ADDR_BITS-1 without wrapping.

Optional Feature:
FILTER_SEQ_CYCLES_EN
- Defined:
  - Adds output cycle_count [15:0].
  - Cleared on accepted start; increments every cycle while busy=1 (pause cycles included).
  - Saturates at 16'hFFFF; holds after done.
  - Cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then start=1 for 1 cycle with num_pixels=3 -> src_addr sequence 0,1,2. dst_we high for exactly 3 consecutive cycles with dst_addr 0,1,2, each one cycle after the matching src_addr. done pulses once, 5 cycles after the start edge. pix_done=3.
- num_pixels=0, start -> no dst_we. done pulses the cycle after the start edge. pix_done=0.
- num_pixels=8, pause high for 4 cycles after the 3rd issue -> writes to 0..7 each exactly once, in order, with a 4-cycle gap after address 2. done 4 cycles later than unpaused. cycle_count=14 when the macro is defined.
- num_pixels=1024 (ADDR_BITS=10) -> last write dst_addr=1023, src_addr never wraps to 0 mid-sweep. done after 1026 cycles. pix_done=1024.
- Start re-asserted mid-sweep and num_pixels changed -> ignored; original N completes. A second start after done starts a new sweep from 0.
- Reset asserted during RUN at src_addr=5 -> next cycle all outputs 0 and state IDLE. A subsequent start sweeps from address 0.
